// File: rtl/mdu_stage.sv
// RV32M multiply/divide unit for the execute stage: one enable pulse starts one operation,
// and one registered done pulse returns its result (multiply: 2 cycles, divide: WIDTH+1 cycles).
module mdu_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic             m_op,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic [1:0]       o_dbg_state
);

   // Handshake: enable is accepted only in IDLE or FIN (and never while rstn=0); every accepted
   // enable yields exactly one single-cycle done, at the earliest in the following cycle, with
   // result valid from the done cycle until the next done. enable while busy in MUL/DIV is ignored.

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t               r_state;
   logic [1:0]           r_sel;
   logic [2*WIDTH-1:0]   r_prod;
   logic [WIDTH-1:0]     r_quo;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_div;
   logic [CW-1:0]        r_cnt;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic [WIDTH-1:0]     r_result;
   logic                 r_done;

   logic                 w_div_signed;
   logic                 w_div_zero;
   logic                 w_overflow;
   logic [WIDTH-1:0]     w_abs1;
   logic [WIDTH-1:0]     w_abs2;
   logic                 w_a_sx;
   logic                 w_b_sx;
   logic [2*WIDTH-1:0]   w_mul_a;
   logic [2*WIDTH-1:0]   w_mul_b;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH:0]       w_rem_sh;
   logic [WIDTH:0]       w_sub;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_rem_nxt;
   logic [WIDTH-1:0]     w_quo_nxt;
   logic [WIDTH-1:0]     w_quo_fix;
   logic [WIDTH-1:0]     w_rem_fix;

   // Operand preparation for a start in this cycle
   assign w_div_signed = ~funct3[0];
   assign w_div_zero   = (rs2 == '0);
   assign w_overflow   = w_div_signed & (rs1 == MIN_INT) & (rs2 == ALL_ONES);
   assign w_abs1       = (w_div_signed & rs1[WIDTH-1]) ? (~rs1 + 1'b1) : rs1;
   assign w_abs2       = (w_div_signed & rs2[WIDTH-1]) ? (~rs2 + 1'b1) : rs2;

   // Sign-extending to 2*WIDTH makes one unsigned multiplier correct for every signedness mix
   assign w_a_sx  = ((funct3[1:0] == 2'b01) | (funct3[1:0] == 2'b10)) & rs1[WIDTH-1];
   assign w_b_sx  = (funct3[1:0] == 2'b01) & rs2[WIDTH-1];
   assign w_mul_a = {{WIDTH{w_a_sx}}, rs1};
   assign w_mul_b = {{WIDTH{w_b_sx}}, rs2};
   assign w_prod  = w_mul_a * w_mul_b;

   // Restoring step: r_quo shifts the dividend out of its MSB and quotient bits into its LSB
   assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
   assign w_sub     = w_rem_sh - {1'b0, r_div};
   assign w_ge      = ~w_sub[WIDTH];
   assign w_rem_nxt = w_ge ? w_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
   assign w_quo_fix = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
   assign w_rem_fix = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state  <= S_IDLE;
         r_sel    <= 2'b00;
         r_prod   <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_FIN: begin
               if (enable) begin
                  r_sel <= funct3[1:0];
                  if (!m_op) begin
                     r_result <= '0;
                     r_done   <= 1'b1;
                     r_state  <= S_FIN;
                  end else if (!funct3[2]) begin
                     r_prod  <= w_prod;
                     r_state <= S_MUL;
                  end else if (w_div_zero) begin
                     r_result <= funct3[1] ? rs1 : ALL_ONES;
                     r_done   <= 1'b1;
                     r_state  <= S_FIN;
                  end else if (w_overflow) begin
                     r_result <= funct3[1] ? '0 : rs1;
                     r_done   <= 1'b1;
                     r_state  <= S_FIN;
                  end else begin
                     r_quo   <= w_abs1;
                     r_div   <= w_abs2;
                     r_rem   <= '0;
                     r_cnt   <= CW'(WIDTH);
                     r_neg_q <= w_div_signed & (rs1[WIDTH-1] ^ rs2[WIDTH-1]);
                     r_neg_r <= w_div_signed & rs1[WIDTH-1];
                     r_state <= S_DIV;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_MUL: begin
               r_result <= (r_sel == 2'b00) ? r_prod[WIDTH-1:0] : r_prod[2*WIDTH-1:WIDTH];
               r_done   <= 1'b1;
               r_state  <= S_FIN;
            end
            S_DIV: begin
               r_quo <= w_quo_nxt;
               r_rem <= w_rem_nxt;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_result <= r_sel[1] ? w_rem_fix : w_quo_fix;
                  r_done   <= 1'b1;
                  r_state  <= S_FIN;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign result      = r_result;
   assign done        = r_done;
   assign busy        = (r_state != S_IDLE);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mdu_stage.sv
// Self-checking bench for mdu_stage: directed vectors, randomized ops against an arithmetic
// reference model, back-to-back issue, ignored enable while busy, and mid-operation reset.
module tb_mdu_stage;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enable;
   logic        m_op;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [31:0] result;
   logic        done;
   logic        busy;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   mdu_stage #(.WIDTH(32)) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .m_op(m_op), .funct3(funct3),
      .rs1(rs1), .rs2(rs2), .result(result), .done(done), .busy(busy),
      .o_dbg_state(dbg_state)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: RV32M semantics from plain integer arithmetic
   function automatic logic [31:0] ref_result(input logic mop, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      int ia, ib;
      if (!mop) return 32'd0;
      if (f3 < 3'd4) begin
         sa = (f3 == 3'd1 || f3 == 3'd2) ? longint'(int'(a)) : longint'(a);
         sb = (f3 == 3'd1) ? longint'(int'(b)) : longint'(b);
         p  = sa * sb;
         return (f3 == 3'd0) ? p[31:0] : p[63:32];
      end
      if (b == 32'd0) return (f3 == 3'd6 || f3 == 3'd7) ? a : 32'hFFFF_FFFF;
      if (f3 == 3'd4 || f3 == 3'd6) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (f3 == 3'd6) ? 32'd0 : a;
         ia = int'(a);
         ib = int'(b);
         return (f3 == 3'd6) ? 32'(ia % ib) : 32'(ia / ib);
      end
      return (f3 == 3'd7) ? (a % b) : (a / b);
   endfunction

   function automatic int ref_latency(input logic mop, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] b);
      if (!mop) return 1;
      if (f3 < 3'd4) return 2;
      if (b == 32'd0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Driver: called at a negedge; drives one enable cycle, waits for done, checks it
   task automatic issue_and_wait(input logic [2:0] f3, input logic mop, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_res,
                                 input int exp_lat, input string name);
      int lat;
      bit got;
      logic [31:0] exp_v;
      exp_q.push_back(exp_res);
      funct3 = f3; m_op = mop; rs1 = a; rs2 = b; enable = 1'b1;
      lat = 0; got = 1'b0;
      while (!got && lat < 60) begin
         @(negedge clk);
         enable = 1'b0;
         rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
         lat++;
         if (done) got = 1'b1;
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: no done within %0d cycles, expected at E+%0d", name, lat, exp_lat);
      end else begin
         checks++;
         if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got E+%0d expected E+%0d", name, lat, exp_lat);
         end
         if (result !== exp_v) begin
            errors++;
            $display("FAIL %s result: got %08h expected %08h", name, result, exp_v);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b expected 0 0", name, done, busy);
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; enable = 1'b1; m_op = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
      repeat (3) @(negedge clk);
      checks++;
      if (result !== 32'd0 || done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: result=%08h done=%b busy=%b expected 0 0 0", result, done, busy);
      end
      rstn = 1'b1; enable = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_enable_ignored: cycle %0d done=%b busy=%b expected 0 0", c, done, busy);
         end
      end
   endtask

   task automatic test_directed();
      logic [2:0]  f3s  [13] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                 3'd4, 3'd7, 3'd4, 3'd6, 3'd0};
      logic        mops [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [31:0] as   [13] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5};
      logic [31:0] bs   [13] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd6};
      logic [31:0] rs   [13] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
      int          lats [13] = '{2, 2, 2, 2, 33, 33, 33, 33, 1, 1, 1, 1, 1};
      for (int i = 0; i < 13; i++)
         issue_and_wait(f3s[i], mops[i], as[i], bs[i], rs[i], lats[i], $sformatf("directed_%0d", i));
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic        mop;
      logic [31:0] a, b;
      for (int i = 0; i < 60; i++) begin
         f3  = 3'($urandom_range(0, 7));
         mop = ($urandom_range(0, 9) != 0);
         a   = rand_operand();
         b   = rand_operand();
         issue_and_wait(f3, mop, a, b, ref_result(mop, f3, a, b), ref_latency(mop, f3, a, b),
                        $sformatf("random_%0d_f3_%0d", i, f3));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2;
      logic        exp_done, exp_busy;
      a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
      exp_q.push_back(ref_result(1'b1, 3'd0, a1, b1));
      exp_q.push_back(ref_result(1'b1, 3'd1, a2, b2));
      funct3 = 3'd0; m_op = 1'b1; rs1 = a1; rs2 = b1; enable = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         enable = 1'b0;
         exp_done = (c == 2 || c == 4);
         exp_busy = (c <= 4);
         checks++;
         if (done !== exp_done || busy !== exp_busy) begin
            errors++;
            $display("FAIL b2b_handshake: E+%0d done=%b busy=%b expected %b %b", c, done, busy, exp_done, exp_busy);
         end
         if (exp_done && exp_q.size() > 0) begin
            checks++;
            if (result !== exp_q[0]) begin
               errors++;
               $display("FAIL b2b_result: E+%0d got %08h expected %08h", c, result, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
         if (c == 2) begin
            funct3 = 3'd1; rs1 = a2; rs2 = b2; enable = 1'b1;
         end
      end
      exp_q.delete();
   endtask

   task automatic test_protocol();
      logic [31:0] a, b, exp_v;
      int n_done, done_cyc;
      a = $urandom; b = 32'($urandom_range(1, 1000));
      exp_v = ref_result(1'b1, 3'd4, a, b);
      n_done = 0; done_cyc = -1;
      funct3 = 3'd4; m_op = 1'b1; rs1 = a; rs2 = b; enable = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         enable = 1'b0;
         if (done) begin
            n_done++;
            done_cyc = c;
            checks++;
            if (result !== exp_v) begin
               errors++;
               $display("FAIL protocol_result: got %08h expected %08h", result, exp_v);
            end
         end
         if (c == 5) begin
            funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; enable = 1'b1;
         end
      end
      checks++;
      if (n_done !== 1 || done_cyc !== 33) begin
         errors++;
         $display("FAIL protocol_done: got %0d pulses last at E+%0d expected 1 at E+33", n_done, done_cyc);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL protocol_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      int n_done;
      n_done = 0;
      funct3 = 3'd5; m_op = 1'b1; rs1 = $urandom; rs2 = 32'($urandom_range(1, 50)); enable = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         enable = 1'b0;
         if (done) n_done++;
         if (c == 10) rstn = 1'b0;
         if (c == 11) rstn = 1'b1;
      end
      checks++;
      if (n_done !== 0) begin
         errors++;
         $display("FAIL reset_mid_done: got %0d done pulses expected 0", n_done);
      end
      checks++;
      if (busy !== 1'b0 || result !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_state: busy=%b result=%08h expected 0 00000000", busy, result);
      end
      issue_and_wait(3'd0, 1'b1, 32'd3, 32'd4, 32'd12, 2, "reset_mid_mul");
   endtask

   initial begin
      enable = 1'b0; m_op = 1'b0; funct3 = 3'd0; rs1 = '0; rs2 = '0; rstn = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_back_to_back();
      test_protocol();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_stage.md
# mdu_stage

Multi-cycle RV32M multiply/divide unit that sits in the execute stage and answers the stall controller's per-stage enable/done handshake. Each accepted `enable` pulse starts exactly one operation. Exactly one single-cycle `done` pulse is returned when the result is valid. Variable latency is absorbed entirely by the handshake: the controller holds all other stages until `done` arrives.

## Interface
- `WIDTH`, default 32: operand and result width. Special-case constants derive from it.
- `clk` input, 1 bit: clock.
- `rstn` input, 1 bit: reset, synchronous, active-low.
- `enable` input, 1 bit: single-cycle start pulse from the stall controller.
- `m_op` input, 1 bit: instruction is an M-extension op. When 0, the operation is a no-op bypass.
- `funct3` input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1` input, WIDTH bits: operand 1, sampled only in the `enable` cycle.
- `rs2` input, WIDTH bits: operand 2, sampled only in the `enable` cycle.
- `result` output, WIDTH bits: registered result. Held stable from the `done` cycle until the next `done`.
- `done` output, 1 bit: registered single-cycle completion pulse.
- `busy` output, 1 bit: high while the state is not IDLE.

## Operation
- States:
  - IDLE: waiting for `enable`.
  - MUL: product registered, selecting result half.
  - DIV: iterating.
  - FIN: `done` asserted.
- IDLE/FIN + `enable`: capture `funct3`, `m_op`, `rs1`, `rs2`, then branch on the operation:
  - `m_op`=0: go to FIN, `result` <= 0.
  - Multiply (funct3<4): register the full 2*WIDTH product of sign-/zero-extended operands (MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned, MUL low half of any), then go to MUL.
  - Divide by zero (`rs2`==0): go to FIN directly with quotient all-ones and remainder `rs1`.
  - Signed overflow (DIV/REM, `rs1`=100..0, `rs2`=all-ones): go to FIN directly with quotient `rs1` and remainder 0.
  - Other divides: load |rs1| and |rs2| (unsigned ops use raw values), remainder accumulator 0, counter WIDTH, then go to DIV.
- MUL: `result` <= low half (MUL) or high half (others), then go to FIN.
- DIV: radix-2 restoring step per cycle, decrement counter. When the counter reaches 1, apply sign fixup in the same step: quotient negated if operand signs differ (signed ops), remainder takes the sign of `rs1`. `result` <= quotient (DIV/DIVU) or remainder (REM/REMU), then go to FIN.
- FIN: `done`=1 for exactly this cycle. If `enable`=0, go to IDLE. If `enable`=1, start a new operation as from IDLE (back-to-back issue).
- `enable` in MUL or DIV is a protocol violation. It is ignored: no capture, no extra `done`, and the current operation completes normally.
- `done` is never asserted without a preceding accepted `enable`, and never in the `enable` cycle itself.

## Timing
- Cycle numbering: `enable` is high in cycle E.
- `done` timing by operation:
  - Bypass and divide special cases: `done` in E+1.
  - Multiply: `done` in E+2.
  - Normal divide: `done` in E+WIDTH+1, which is E+33 for WIDTH=32.
- `busy` is high from E+1 through the `done` cycle inclusive. It stays high continuously across back-to-back operations.
- `result` updates on the edge that enters FIN and is valid throughout the `done` cycle.
- Reset values: state IDLE, `done`=0, `busy`=0, `result`=0, counter 0.
- Reset mid-operation (MUL or DIV) aborts the operation. No `done` follows, and `result` is 0 after reset.
- `enable` is sampled in the same cycle `rstn`=0: reset wins and the operation is not accepted.

## Test plan
- After reset, MUL `rs1`=7, `rs2`=-3 -> `done` in E+2, `result`=0xFFFFFFEB. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> `result`=0xFFFFFFFE.
- DIV -7/2 -> `done` in E+33, `result`=0xFFFFFFFD. REM -7/2 -> `result`=0xFFFFFFFF. DIVU 100/7 -> `result`=14. REMU 100/7 -> `result`=2.
- DIV 5/0 -> `done` in E+1, `result`=0xFFFFFFFF. REMU 5/0 -> `result`=5. DIV 0x80000000/0xFFFFFFFF -> `result`=0x80000000. REM of the same operands -> `result`=0.
- Back-to-back: a second `enable` in the first op's `done` cycle (MUL then MULH) -> two `done` pulses at E+2 and E+4, `busy` high continuously from E+1 to E+4.
- Protocol robustness: `enable` pulsed in cycle E+5 of a normal DIV -> exactly one `done` at E+33 with the correct quotient. `m_op`=0 -> `done` in E+1, `result`=0.
- `rstn` low at E+10 of a DIV -> `done` never asserted, `busy`=0 and `result`=0 after reset. A following MUL 3x4 -> `result`=12.
